// File: rtl/acondicionador_de_sensores_pkg.sv
// Shared constants for the sensor conditioning stage: channel count,
// channel-to-index mapping, default filter parameters and the
// counter-width helper used by every debounce channel.
package acondicionador_de_sensores_pkg;

  localparam int NUM_SENSORES    = 4;

  localparam int IDX_TEMPERATURA = 0;
  localparam int IDX_MANUAL      = 1;
  localparam int IDX_HUMO        = 2;
  localparam int IDX_SOBRECARGA  = 3;

  localparam int PRESC_DEF       = 1;
  localparam int N_DEB_DEF       = 16;

  // Width of a debounce counter able to hold 0..n_deb-1 with one spare bit.
  function automatic int ancho_contador(input int n_deb);
    return $clog2(n_deb) + 1;
  endfunction

endpackage

// File: rtl/acondicionador_de_sensores_filtro_antirrebote.sv
// One sensor channel: two-flop synchroniser, tick-driven stability counter
// and the debounced level register. The "cambio" flag is combinational and
// marks the tick on which the debounced level is about to flip, so that the
// top can register it in step with the level itself.
module filtro_antirrebote
  import acondicionador_de_sensores_pkg::*;
#(
  parameter int N_DEB = N_DEB_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic entrada,
  output logic salida,
  output logic cambio
);

  localparam int CW = ancho_contador(N_DEB);

  logic          sync1_r;
  logic          sync2_r;
  logic          salida_r;
  logic [CW-1:0] cuenta_r;
  logic          diferente_s;
  logic          expira_s;

  // Mismatch detection and the "this tick adopts the new level" condition.
  always_comb begin
    diferente_s = sync2_r ^ salida_r;
    if (tick && diferente_s && (cuenta_r == CW'(N_DEB - 1))) begin
      expira_s = 1'b1;
    end else begin
      expira_s = 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous raw sensor line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= entrada;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter and debounced level; only tick cycles move them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta_r <= {CW{1'b0}};
      salida_r <= 1'b0;
    end else if (tick) begin
      if (!diferente_s) begin
        cuenta_r <= {CW{1'b0}};
      end else if (expira_s) begin
        salida_r <= sync2_r;
        cuenta_r <= {CW{1'b0}};
      end else begin
        cuenta_r <= cuenta_r + CW'(1);
      end
    end else begin
      cuenta_r <= cuenta_r;
      salida_r <= salida_r;
    end
  end

  assign salida = salida_r;
  assign cambio = expira_s;

endmodule

// File: rtl/acondicionador_de_sensores.sv
// Sensor conditioning top: shared sample-tick prescaler, four independent
// debounce channels and the registered change strobe for the decoder.
module acondicionador_de_sensores
  import acondicionador_de_sensores_pkg::*;
#(
  parameter int PRESC = PRESC_DEF,
  parameter int N_DEB = N_DEB_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Temperatura_in,
  input  logic Manual_in,
  input  logic Humo_in,
  input  logic SobreCarga_in,
  output logic Temperatura,
  output logic Manual,
  output logic Humo,
  output logic SobreCarga,
  output logic Cambio
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0]           presc_r;
  logic                    tick_s;
  logic                    cambio_r;
  logic [NUM_SENSORES-1:0] entradas_s;
  logic [NUM_SENSORES-1:0] salidas_s;
  logic [NUM_SENSORES-1:0] cambios_s;

  assign entradas_s[IDX_TEMPERATURA] = Temperatura_in;
  assign entradas_s[IDX_MANUAL]      = Manual_in;
  assign entradas_s[IDX_HUMO]        = Humo_in;
  assign entradas_s[IDX_SOBRECARGA]  = SobreCarga_in;

  // Sample tick: asserted in the last cycle of each prescaler period.
  always_comb begin
    if (presc_r == PW'(PRESC - 1)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler counting 0..PRESC-1 and wrapping on the tick.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  for (genvar g = 0; g < NUM_SENSORES; g++) begin : g_canal
    filtro_antirrebote #(
      .N_DEB (N_DEB)
    ) u_filtro (
      .clk     (CLK),
      .rst_n   (RST_N),
      .tick    (tick_s),
      .entrada (entradas_s[g]),
      .salida  (salidas_s[g]),
      .cambio  (cambios_s[g])
    );
  end

  // Change strobe registered on the same edge the new levels are loaded.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cambio_r <= 1'b0;
    end else begin
      cambio_r <= |cambios_s;
    end
  end

  assign Temperatura = salidas_s[IDX_TEMPERATURA];
  assign Manual      = salidas_s[IDX_MANUAL];
  assign Humo        = salidas_s[IDX_HUMO];
  assign SobreCarga  = salidas_s[IDX_SOBRECARGA];
  assign Cambio      = cambio_r;

endmodule

// File: tb/tb_acondicionador_de_sensores.sv
// Bench for the sensor conditioning stage. Three instances with different
// parameter sets share one clock: A (PRESC=1,N_DEB=4), B (PRESC=4,N_DEB=4),
// C (PRESC=1,N_DEB=8). Instance A is tracked every cycle by a reference model.
module tb_acondicionador_de_sensores;
  import acondicionador_de_sensores_pkg::*;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] in_a, in_b, in_c;
  wire  [3:0] o_a, o_b, o_c;
  wire        camb_a, camb_b, camb_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state for instance A
  logic [3:0] m_p1, m_p2, m_o;
  logic       m_c;
  int         m_run [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  acondicionador_de_sensores #(.PRESC(1), .N_DEB(4)) dut_a (
    .CLK(clk), .RST_N(rst_a),
    .Temperatura_in(in_a[0]), .Manual_in(in_a[1]), .Humo_in(in_a[2]), .SobreCarga_in(in_a[3]),
    .Temperatura(o_a[0]), .Manual(o_a[1]), .Humo(o_a[2]), .SobreCarga(o_a[3]), .Cambio(camb_a));

  acondicionador_de_sensores #(.PRESC(4), .N_DEB(4)) dut_b (
    .CLK(clk), .RST_N(rst_b),
    .Temperatura_in(in_b[0]), .Manual_in(in_b[1]), .Humo_in(in_b[2]), .SobreCarga_in(in_b[3]),
    .Temperatura(o_b[0]), .Manual(o_b[1]), .Humo(o_b[2]), .SobreCarga(o_b[3]), .Cambio(camb_b));

  acondicionador_de_sensores #(.PRESC(1), .N_DEB(8)) dut_c (
    .CLK(clk), .RST_N(rst_c),
    .Temperatura_in(in_c[0]), .Manual_in(in_c[1]), .Humo_in(in_c[2]), .SobreCarga_in(in_c[3]),
    .Temperatura(o_c[0]), .Manual(o_c[1]), .Humo(o_c[2]), .SobreCarga(o_c[3]), .Cambio(camb_c));

  // Advance one clock edge and update the model of instance A:
  // the filter sees each raw value two edges after it is sampled, and a level
  // is adopted once 4 consecutive ticks disagree with the current level.
  task automatic step();
    logic [3:0] iv;
    logic       r;
    logic [3:0] seen;
    logic [3:0] chg;
    iv = in_a;
    r  = rst_a;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      m_p1 = 4'h0; m_p2 = 4'h0; m_o = 4'h0; m_c = 1'b0;
      for (int ch = 0; ch < 4; ch++) m_run[ch] = 0;
    end else begin
      seen = m_p2;
      m_p2 = m_p1;
      m_p1 = iv;
      chg  = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        if (seen[ch] !== m_o[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == 4) begin
            m_o[ch]   = seen[ch];
            m_run[ch] = 0;
            chg[ch]   = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_c = |chg;
    end
  endtask

  task automatic test_reset();
    logic [3:0] eo;
    logic       ec;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    in_a = 4'hF; in_b = 4'h0; in_c = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({o_a, camb_a, o_b, camb_b, o_c, camb_c} !== 15'h0) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got a=%b/%b b=%b/%b c=%b/%b want all 0",
                 i, o_a, camb_a, o_b, camb_b, o_c, camb_c);
      end
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      eo = (i >= 6) ? 4'hF : 4'h0;
      ec = (i == 6);
      total++;
      if (o_a !== eo || camb_a !== ec) begin
        bad++;
        $display("FAIL reset_release edge=%0d got o=%b c=%b want o=%b c=%b", i, o_a, camb_a, eo, ec);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [3:0] eo;
    logic       ec;
    in_a = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (o_a !== m_o || camb_a !== m_c) begin
        bad++;
        $display("FAIL settle_low cyc=%0d got o=%b c=%b want o=%b c=%b", cyc, o_a, camb_a, m_o, m_c);
      end
    end
    in_a[IDX_HUMO] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      eo = (i >= 6) ? 4'b0100 : 4'b0000;
      ec = (i == 6);
      total++;
      if (o_a !== eo || camb_a !== ec) begin
        bad++;
        $display("FAIL humo_rise edge=%0d got o=%b c=%b want o=%b c=%b", i, o_a, camb_a, eo, ec);
      end
    end
    in_a[IDX_HUMO] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      eo = (i >= 6) ? 4'b0000 : 4'b0100;
      ec = (i == 6);
      total++;
      if (o_a !== eo || camb_a !== ec) begin
        bad++;
        $display("FAIL humo_fall edge=%0d got o=%b c=%b want o=%b c=%b", i, o_a, camb_a, eo, ec);
      end
    end
  endtask

  task automatic test_glitch();
    logic em;
    logic ec;
    in_a[IDX_MANUAL] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) in_a[IDX_MANUAL] = 1'b0;
      step();
      total++;
      if (o_a !== 4'h0 || camb_a !== 1'b0) begin
        bad++;
        $display("FAIL glitch_reject edge=%0d got o=%b c=%b want o=0000 c=0", i, o_a, camb_a);
      end
    end
    in_a[IDX_MANUAL] = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 6) in_a[IDX_MANUAL] = 1'b0;
      step();
      em = (i >= 6 && i <= 10);
      ec = (i == 6 || i == 11);
      total++;
      if (o_a !== {2'b00, em, 1'b0} || camb_a !== ec) begin
        bad++;
        $display("FAIL pulse5_accept edge=%0d got o=%b c=%b want manual=%b c=%b", i, o_a, camb_a, em, ec);
      end
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    in_a[IDX_TEMPERATURA] = 1'b1;
    in_a[IDX_SOBRECARGA]  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_a[IDX_HUMO] = ~in_a[IDX_HUMO];
      step();
      if (camb_a === 1'b1) pulses++;
      total++;
      if (o_a !== m_o || camb_a !== m_c || o_a[IDX_HUMO] !== 1'b0 ||
          o_a[IDX_TEMPERATURA] !== o_a[IDX_SOBRECARGA]) begin
        bad++;
        $display("FAIL simultaneous edge=%0d got o=%b c=%b want o=%b c=%b", i, o_a, camb_a, m_o, m_c);
      end
    end
    total++;
    if (pulses != 1 || o_a !== 4'b1001) begin
      bad++;
      $display("FAIL simultaneous_pulses got pulses=%0d o=%b want pulses=1 o=1001", pulses, o_a);
    end
    in_a = 4'h0;
    for (int i = 1; i <= 8; i++) step();
    total++;
    if (o_a !== 4'h0) begin
      bad++;
      $display("FAIL simultaneous_clear got o=%b want 0000", o_a);
    end
  endtask

  task automatic test_back_to_back();
    logic ec;
    in_a[IDX_TEMPERATURA] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 2) in_a[IDX_SOBRECARGA] = 1'b1;
      step();
      ec = (i == 6 || i == 7);
      total++;
      if (camb_a !== ec || o_a !== m_o) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got o=%b c=%b want o=%b c=%b", i, o_a, camb_a, m_o, ec);
      end
    end
    in_a = 4'h0;
    for (int i = 1; i <= 9; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 3) == 0) in_a[ch] = ~in_a[ch];
      rst_a = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
      total++;
      if (o_a !== m_o || camb_a !== m_c) begin
        bad++;
        $display("FAIL random cyc=%0d got o=%b c=%b want o=%b c=%b", cyc, o_a, camb_a, m_o, m_c);
      end
    end
    rst_a = 1'b1;
  endtask

  task automatic test_prescaler();
    int n;
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < int'($urandom_range(0, 7)); w++) step();
      in_b[IDX_SOBRECARGA] = 1'b1;
      n = 0;
      while (o_b[IDX_SOBRECARGA] !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      total++;
      if (n < 15 || n > 18 || o_b[2:0] !== 3'b000) begin
        bad++;
        $display("FAIL presc_latency trial=%0d got edges=%0d o=%b want 15..18 o=1000", t, n, o_b);
      end
      in_b[IDX_SOBRECARGA] = 1'b0;
      for (int w = 0; w < 25; w++) step();
      total++;
      if (o_b !== 4'h0) begin
        bad++;
        $display("FAIL presc_fall trial=%0d got o=%b want 0000", t, o_b);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic eh;
    logic ec;
    in_c[IDX_HUMO] = 1'b1;
    for (int i = 1; i <= 7; i++) step();
    rst_c = 1'b0;
    step();
    total++;
    if (o_c !== 4'h0 || camb_c !== 1'b0) begin
      bad++;
      $display("FAIL midcount_reset got o=%b c=%b want o=0000 c=0", o_c, camb_c);
    end
    rst_c = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      eh = (i >= 10);
      ec = (i == 10);
      total++;
      if (o_c !== {1'b0, eh, 2'b00} || camb_c !== ec) begin
        bad++;
        $display("FAIL midcount_release edge=%0d got o=%b c=%b want humo=%b c=%b", i, o_c, camb_c, eh, ec);
      end
    end
  endtask

  initial begin
    m_p1 = 4'h0; m_p2 = 4'h0; m_o = 4'h0; m_c = 1'b0;
    for (int ch = 0; ch < 4; ch++) m_run[ch] = 0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_prescaler();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
